// File: rtl/accontrol_pkg.sv
// Shared constants and the decoded control word for the accumulator controller.
// Carries the accumulator source-mux encodings used by the decoder and the output stage.
package accontrol_pkg;

  localparam logic MUX_SEL_ALU = 1'b0;
  localparam logic MUX_SEL_IN  = 1'b1;

  typedef struct packed {
    logic mux_sel;
    logic ac_wr;
    logic err;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mux_sel: MUX_SEL_ALU, ac_wr: 1'b0, err: 1'b0};

endpackage

// File: rtl/accontrol_dec.sv
// Combinational priority decoder: jump/jumpC over InA over sin/twone over idle.
// Zero latency; no flow control, the result is consumed every cycle.
module accontrol_dec
  import accontrol_pkg::*;
(
  input  logic  jump,
  input  logic  jumpC,
  input  logic  sin,
  input  logic  InA,
  input  logic  twone,
  output ctrl_t ctrl
);

  logic any_jump;
  logic alu_op;

  assign any_jump = jump | jumpC;
  assign alu_op   = sin | twone;

  always_comb begin
    ctrl = CTRL_IDLE;
    if (any_jump) begin
      ctrl.ac_wr   = 1'b0;
      ctrl.mux_sel = MUX_SEL_ALU;
    end else if (InA) begin
      ctrl.ac_wr   = 1'b1;
      ctrl.mux_sel = MUX_SEL_IN;
    end else if (alu_op) begin
      ctrl.ac_wr   = 1'b1;
      ctrl.mux_sel = MUX_SEL_ALU;
    end
    // err is informational only; it never feeds back into the write decode above.
    ctrl.err = (jump & jumpC) | (InA & alu_op & ~any_jump);
  end

endmodule

// File: rtl/accontrol.sv
// Accumulator write/mux controller: decoded instruction flags -> registered controls.
// One-cycle latency from inputs to outputs; no backpressure, new decode every cycle.
module accontrol
  import accontrol_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic jump,
  input  logic jumpC,
  input  logic sin,
  input  logic InA,
  input  logic twone,
  output logic saidaMux,
  output logic saidaAc,
  output logic err
);

  ctrl_t ctrl;

  accontrol_dec u_dec (
    .jump  (jump),
    .jumpC (jumpC),
    .sin   (sin),
    .InA   (InA),
    .twone (twone),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      saidaMux <= MUX_SEL_ALU;
      saidaAc  <= 1'b0;
      err      <= 1'b0;
    end else begin
      saidaMux <= ctrl.mux_sel;
      saidaAc  <= ctrl.ac_wr;
      err      <= ctrl.err;
    end
  end

endmodule

// File: tb/tb_accontrol.sv
// Scoreboard bench for accontrol: driver queues expected outputs, monitor checks each cycle.
module tb_accontrol;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jump = 1'b0, jumpC = 1'b0, sin = 1'b0, InA = 1'b0, twone = 1'b0;
  logic saidaMux, saidaAc, err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic ac;
    logic mux;
    logic er;
    string tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  accontrol dut (
    .clk      (clk),
    .rst      (rst),
    .jump     (jump),
    .jumpC    (jumpC),
    .sin      (sin),
    .InA      (InA),
    .twone    (twone),
    .saidaMux (saidaMux),
    .saidaAc  (saidaAc),
    .err      (err)
  );

  // Reference model straight from the decode rules; v = {jump, jumpC, sin, InA, twone}.
  function automatic exp_t model(input logic r, input logic [4:0] v, input string tag);
    exp_t e;
    logic j, jc, s, ia, tw;
    {j, jc, s, ia, tw} = v;
    e.tag = tag;
    e.ac = 1'b0; e.mux = 1'b0; e.er = 1'b0;
    if (!r) begin
      if (j || jc) begin
        e.ac = 1'b0; e.mux = 1'b0;
      end else if (ia) begin
        e.ac = 1'b1; e.mux = 1'b1;
      end else if (s || tw) begin
        e.ac = 1'b1; e.mux = 1'b0;
      end
      e.er = (j && jc) || (ia && (s || tw) && !(j || jc));
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [4:0] v, input string tag);
    @(negedge clk);
    rst = r;
    {jump, jumpC, sin, InA, twone} = v;
    sb.push_back(model(r, v, tag));
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (saidaAc !== e.ac) begin
          fails++;
          $display("FAIL %s saidaAc: got %b want %b", e.tag, saidaAc, e.ac);
        end
        tests++;
        if (saidaMux !== e.mux) begin
          fails++;
          $display("FAIL %s saidaMux: got %b want %b", e.tag, saidaMux, e.mux);
        end
        tests++;
        if (err !== e.er) begin
          fails++;
          $display("FAIL %s err: got %b want %b", e.tag, err, e.er);
        end
        tests++;
        if (saidaMux === 1'b1 && saidaAc !== 1'b1) begin
          fails++;
          $display("FAIL %s mux_implies_ac: got mux=%b ac=%b want ac=1", e.tag, saidaMux, saidaAc);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    logic r;
    logic [4:0] v;

    drive(1'b1, 5'b11111, "reset_all_ones");
    drive(1'b1, 5'b00000, "reset_idle");
    drive(1'b0, 5'b10111, "jump_over_all");
    drive(1'b0, 5'b11111, "jump_jumpc_err");
    drive(1'b0, 5'b01000, "jumpc_only");
    drive(1'b0, 5'b00100, "sin_only");
    drive(1'b0, 5'b00101, "sin_twone");
    drive(1'b0, 5'b00001, "twone_only");
    drive(1'b0, 5'b00010, "ina_only");
    drive(1'b0, 5'b00011, "ina_twone_err");
    drive(1'b0, 5'b00110, "ina_sin_err");
    drive(1'b0, 5'b00000, "idle_a");
    drive(1'b0, 5'b00100, "step_sin");
    drive(1'b0, 5'b00000, "idle_b");
    drive(1'b0, 5'b00010, "ina_hold_a");
    drive(1'b1, 5'b00010, "ina_mid_reset");
    drive(1'b0, 5'b00010, "ina_hold_b");
    drive(1'b0, 5'b00010, "ina_hold_c");

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 15) == 0);
      v = 5'($urandom);
      drive(r, v, "random");
    end

    @(negedge clk);
    rst = 1'b0;
    {jump, jumpC, sin, InA, twone} = 5'b00000;

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accontrol.md
ACCONTROL -- requirements
Module: accontrol

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port: jump  input  1  unconditional jump instruction decoded this cycle.
REQ-005 Port: jumpC  input  1  conditional jump instruction decoded this cycle.
REQ-006 Port: sin  input  1  ALU operation whose result is written to the accumulator.
REQ-007 Port: InA  input  1  load accumulator from the external input bus.
REQ-008 Port: twone  input  1  two-operand (operand 1 & operand 2) ALU operation writing the accumulator.
REQ-009 Port: saidaMux  output  1  accumulator source-mux select: 0 = ALU result, 1 = external input.
REQ-010 Port: saidaAc  output  1  accumulator write enable.
REQ-011 Port: err  output  1  illegal input combination flag.
REQ-012 Parameters: none.

Function
REQ-013 All outputs SHALL be registered, updating on the clk rising edge, with 1-cycle latency from the inputs.
REQ-014 Decode priority, highest first: jump|jumpC, then InA, then sin|twone, then idle.
REQ-015 If jump=1 or jumpC=1: next saidaAc=0 and saidaMux=0, regardless of all other inputs.
REQ-016 Else if InA=1: next saidaAc=1 and saidaMux=1.
REQ-017 Else if sin=1 or twone=1: next saidaAc=1 and saidaMux=0.
REQ-018 Else (all inputs 0): next saidaAc=0 and saidaMux=0.
REQ-019 saidaMux SHALL be 1 only when saidaAc is 1.
REQ-020 err SHALL be set for the next cycle when either condition holds: (a) jump=1 and jumpC=1; (b) InA=1 and (sin=1 or twone=1) with no jump active.
REQ-021 sin=1 with twone=1 SHALL be legal and SHALL NOT set err.
REQ-022 err SHALL NOT be sticky; it reflects only the previous cycle's inputs.
REQ-023 Simultaneous inputs SHALL be resolved purely by REQ-014; err does not alter saidaAc or saidaMux.
REQ-024 No internal state SHALL exist beyond the three output registers.

Reset
REQ-025 While rst=1 at a clk edge: saidaAc=0, saidaMux=0, err=0, overriding all inputs.
REQ-026 The first clk edge with rst=0 SHALL load the decode of the inputs present at that edge.
REQ-027 Reset asserted mid-operation SHALL clear the outputs at the next edge without any pending write completing.

Structure
REQ-028 A shared package SHALL hold the mux-select constants MUX_SEL_ALU=1'b0 and MUX_SEL_IN=1'b1.
REQ-029 The combinational priority decoder SHALL be a sub-module named accontrol_dec, instantiated once, followed by the output register stage in accontrol.

Verification
REQ-030 Reset: rst=1 with all inputs 1 -> after the edge, saidaAc=0, saidaMux=0, err=0.
REQ-031 Jump priority: jump=1 with sin=1, InA=1, twone=1 -> next cycle saidaAc=0, saidaMux=0, err=0; repeat with jump=1 and jumpC=1 -> err=1.
REQ-032 ALU write: sin=1 only -> saidaAc=1, saidaMux=0; sin=1 and twone=1 -> same values, err=0; twone=1 only -> same values.
REQ-033 Input load: InA=1 only -> saidaAc=1, saidaMux=1; InA=1 and twone=1 -> saidaAc=1, saidaMux=1, err=1.
REQ-034 Latency and idle: step inputs 00000 -> 00100 -> 00000 (order jump, jumpC, sin, InA, twone) -> saidaAc reads 0, 1, 0, each change one edge after the input change.
REQ-035 Mid-sequence reset: InA=1 held, rst pulsed for one cycle -> outputs are 0 for exactly that cycle, then return to saidaAc=1, saidaMux=1.
